// File: rtl/hdmi_period_sequencer.sv
// HDMI period sequencer: raster counters, sync generation and per-pixel period
// selection (control / preamble / guard / video) feeding three TMDS encoders.
module hdmi_period_sequencer #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    output logic [11:0] cx,
    output logic [10:0] cy,
    input  logic [23:0] rgb,
    output logic [2:0]  mode,
    output logic [1:0]  ctrl0,
    output logic [1:0]  ctrl1,
    output logic [1:0]  ctrl2,
    output logic [23:0] video_data,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned CX_W    = 12;
    localparam int unsigned CY_W    = 11;

    if (H_TOTAL > 4096 || V_TOTAL > 2048 || H_BACK < 10) begin : g_bad_params
        $error("hdmi_period_sequencer: H_TOTAL/V_TOTAL exceed counter width or H_BACK < 10");
    end

    // Column decode points; preamble and guard sit at the very end of the back porch
    localparam logic [CX_W-1:0] CX_ACT      = CX_W'(H_ACTIVE);
    localparam logic [CX_W-1:0] CX_LAST     = CX_W'(H_TOTAL - 1);
    localparam logic [CX_W-1:0] HS_START    = CX_W'(H_ACTIVE + H_FRONT);
    localparam logic [CX_W-1:0] HS_END      = CX_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CX_W-1:0] PRE_START   = CX_W'(H_TOTAL - 10);
    localparam logic [CX_W-1:0] PRE_END     = CX_W'(H_TOTAL - 3);
    localparam logic [CX_W-1:0] GUARD_START = CX_W'(H_TOTAL - 2);

    // Line decode points
    localparam logic [CY_W-1:0] CY_ACT      = CY_W'(V_ACTIVE);
    localparam logic [CY_W-1:0] CY_ACT_LAST = CY_W'(V_ACTIVE - 1);
    localparam logic [CY_W-1:0] CY_LAST     = CY_W'(V_TOTAL - 1);
    localparam logic [CY_W-1:0] VS_START    = CY_W'(V_ACTIVE + V_FRONT);
    localparam logic [CY_W-1:0] VS_END      = CY_W'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [1:0] ST_CONTROL  = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_GUARD    = 2'd2;
    localparam logic [1:0] ST_VIDEO    = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [2:0]  mode_next;
    logic [1:0]  ctrl0_next;
    logic [1:0]  ctrl1_next;
    logic [1:0]  ctrl2_next;
    logic [23:0] video_next;
    logic        frame_start_next;

    logic is_active;
    logic is_hs;
    logic is_vs;
    logic next_act;
    logic is_pre;
    logic is_guard;

    // Raster counters; reset parks them just before the last line's preamble
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cx <= CX_ACT;
            cy <= CY_LAST;
        end else if (cx == CX_LAST) begin
            cx <= '0;
            cy <= (cy == CY_LAST) ? '0 : cy + CY_W'(1);
        end else begin
            cx <= cx + CX_W'(1);
        end
    end

    // Phase decode of the current counter position
    always_comb begin
        is_active = (cx < CX_ACT) && (cy < CY_ACT);
        is_hs     = (cx >= HS_START) && (cx < HS_END);
        is_vs     = (cy >= VS_START) && (cy < VS_END);
        next_act  = (cy == CY_LAST) || (cy < CY_ACT_LAST);
        is_pre    = next_act && (cx >= PRE_START) && (cx <= PRE_END);
        is_guard  = next_act && (cx >= GUARD_START);
    end

    // Next period state and the output words it implies
    always_comb begin
        state_next       = ST_CONTROL;
        mode_next        = 3'd0;
        ctrl1_next       = 2'b00;
        ctrl2_next       = 2'b00;
        video_next       = '0;
        frame_start_next = 1'b0;
        ctrl0_next       = {is_vs ? VSYNC_POL : ~VSYNC_POL, is_hs ? HSYNC_POL : ~HSYNC_POL};
        if (is_active) begin
            state_next       = ST_VIDEO;
            mode_next        = 3'd1;
            video_next       = rgb;
            frame_start_next = (cx == '0) && (cy == '0);
        end else if (is_guard) begin
            state_next = ST_GUARD;
            mode_next  = 3'd2;
        end else if (is_pre) begin
            state_next = ST_PREAMBLE;
            ctrl1_next = 2'b01;
        end
    end

    // State and output registers, one clock behind the counters
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state       <= ST_CONTROL;
            mode        <= 3'd0;
            ctrl0       <= {~VSYNC_POL, ~HSYNC_POL};
            ctrl1       <= 2'b00;
            ctrl2       <= 2'b00;
            video_data  <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            mode        <= mode_next;
            ctrl0       <= ctrl0_next;
            ctrl1       <= ctrl1_next;
            ctrl2       <= ctrl2_next;
            video_data  <= video_next;
            frame_start <= frame_start_next;
        end
    end

    function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
        logic ok;
        ok = (to == from);
        case (from)
            ST_CONTROL:  ok = ok || (to == ST_PREAMBLE);
            ST_PREAMBLE: ok = ok || (to == ST_GUARD);
            ST_GUARD:    ok = ok || (to == ST_VIDEO);
            default:     ok = ok || (to == ST_CONTROL);
        endcase
        return ok;
    endfunction

    // Periods must advance strictly CONTROL->PREAMBLE->GUARD->VIDEO->CONTROL
    always_ff @(posedge clk_pixel) begin
        if (!reset) begin
            assert (legal_step(state, state_next))
            else $error("illegal period transition %0d -> %0d", state, state_next);
        end
    end

endmodule
